// File: rtl/vlc_bit_packer.sv
// Packs variable-length codewords MSB-first into 32-bit words; 1-cycle emit latency, output register stalls on !output_ready and blocks input once 32 bits are held.
// Optional running bit counter on bit_total when VLC_BIT_PACKER_BITCOUNT_EN is defined.
module vlc_bit_packer (
   input  logic        clk,
   input  logic        reset,
   input  logic        input_valid,
   input  logic [31:0] sum_n,
   input  logic [31:0] codeword_length,
   output logic        input_ready,
   input  logic        flush,
   output logic        output_valid,
   output logic [31:0] output_data,
   input  logic        output_ready,
   output logic        flush_done,
`ifdef VLC_BIT_PACKER_BITCOUNT_EN
   output logic [31:0] bit_total,
`endif
   output logic        len_error
);

   typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

   state_t      state_q, state_d;
   logic [63:0] acc_q, acc_d;
   logic [6:0]  cnt_q, cnt_d;
   logic [31:0] od_q, od_d;
   logic        ov_q, ov_d;
   logic        le_q, le_d;

   logic        accept;
   logic        legal;
   logic        out_free;
   logic [5:0]  len6;
   logic [31:0] mask;
   logic [6:0]  sh;
   logic [63:0] ins;

   assign accept   = input_valid && input_ready;
   assign legal    = (codeword_length <= 32'd32);
   assign len6     = codeword_length[5:0];
   assign out_free = !ov_q || output_ready;
   // A 32-bit shift by 32 yields zero, so L=32 keeps every bit of sum_n.
   assign mask     = ~(32'hFFFF_FFFF << len6);
   assign sh       = 7'd64 - cnt_q - {1'b0, len6};
   assign ins      = {32'd0, sum_n & mask} << sh;

   always_ff @(posedge clk) begin
      if (reset) state_q <= RUN;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (flush) state_d = FLUSH;
         FLUSH:   if (cnt_q == 7'd0) state_d = DONE;
         DONE:    state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      input_ready = (state_q == RUN) && (cnt_q < 7'd32);
      flush_done  = (state_q == DONE);
   end

   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      od_d  = od_q;
      ov_d  = ov_q;
      le_d  = le_q || (accept && !legal);
      if (ov_q && output_ready) ov_d = 1'b0;
      if (cnt_q >= 7'd32 && out_free) begin
         od_d  = acc_q[63:32];
         acc_d = {acc_q[31:0], 32'd0};
         cnt_d = cnt_q - 7'd32;
         ov_d  = 1'b1;
      end else if (state_q == FLUSH && cnt_q != 7'd0 && out_free) begin
         // Bits below the valid data are already zero, so the pad is free.
         od_d  = acc_q[63:32];
         acc_d = 64'd0;
         cnt_d = 7'd0;
         ov_d  = 1'b1;
      end else if (accept && legal) begin
         acc_d = acc_q | ins;
         cnt_d = cnt_q + {1'b0, len6};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q <= 64'd0;
         cnt_q <= 7'd0;
         od_q  <= 32'd0;
         ov_q  <= 1'b0;
         le_q  <= 1'b0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         od_q  <= od_d;
         ov_q  <= ov_d;
         le_q  <= le_d;
      end
   end

   assign output_valid = ov_q;
   assign output_data  = od_q;
   assign len_error    = le_q;

`ifdef VLC_BIT_PACKER_BITCOUNT_EN
   logic [31:0] total_q, total_d;

   assign total_d = (accept && legal) ? total_q + {26'd0, len6} : total_q;

   always_ff @(posedge clk) begin
      if (reset) total_q <= 32'd0;
      else       total_q <= total_d;
   end

   assign bit_total = total_q;
`endif

endmodule

// File: tb/tb_vlc_bit_packer.sv
// Directed table-driven bench for vlc_bit_packer plus hand sequences for stall, flush and reset corners.
module tb_vlc_bit_packer;

   logic        clk;
   logic        reset;
   logic        input_valid;
   logic [31:0] sum_n;
   logic [31:0] codeword_length;
   logic        input_ready;
   logic        flush;
   logic        output_valid;
   logic [31:0] output_data;
   logic        output_ready;
   logic        flush_done;
   logic        len_error;
`ifdef VLC_BIT_PACKER_BITCOUNT_EN
   logic [31:0] bit_total;
`endif

   vlc_bit_packer dut (
      .clk             (clk),
      .reset           (reset),
      .input_valid     (input_valid),
      .sum_n           (sum_n),
      .codeword_length (codeword_length),
      .input_ready     (input_ready),
      .flush           (flush),
      .output_valid    (output_valid),
      .output_data     (output_data),
      .output_ready    (output_ready),
      .flush_done      (flush_done),
`ifdef VLC_BIT_PACKER_BITCOUNT_EN
      .bit_total       (bit_total),
`endif
      .len_error       (len_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [31:0] sum;
      logic [31:0] len;
      logic        fl;
      logic        ordy;
      logic        e_ir;
      logic        e_ov;
      logic [31:0] e_od;
      logic        e_fd;
      logic        e_le;
   } vec_t;

   vec_t vt[24];
   int   n_rows;
   int   n_chk;
   int   n_pass;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic row(input logic v, input logic [31:0] s, input logic [31:0] l, input logic fl,
                      input logic ordy, input logic ir, input logic ov, input logic [31:0] od,
                      input logic fd, input logic le);
      vt[n_rows].v    = v;
      vt[n_rows].sum  = s;
      vt[n_rows].len  = l;
      vt[n_rows].fl   = fl;
      vt[n_rows].ordy = ordy;
      vt[n_rows].e_ir = ir;
      vt[n_rows].e_ov = ov;
      vt[n_rows].e_od = od;
      vt[n_rows].e_fd = fd;
      vt[n_rows].e_le = le;
      n_rows++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for input_ready (bounded), then presents one codeword for one edge.
   task automatic send(input logic [31:0] s, input logic [31:0] l);
      int n;
      n = 0;
      while (!input_ready && n < 20) begin
         tick();
         n++;
      end
      chk("send_ready", {31'd0, input_ready}, 32'd1);
      input_valid     = 1'b1;
      sum_n           = s;
      codeword_length = l;
      tick();
      input_valid     = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_rows = 0;
      n_chk  = 0;
      n_pass = 0;
      reset = 1'b1; input_valid = 1'b0; sum_n = 32'd0; codeword_length = 32'd0;
      flush = 1'b0; output_ready = 1'b1;

      //   v     sum            len    fl    or     ir    ov    od             fd    le
      row(1'b1, 32'h5,        32'd3,  1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0);
      row(1'b1, 32'h1FFFFFFF, 32'd29, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0);
      row(1'b0, 32'h0,        32'd0,  1'b0, 1'b1, 1'b1, 1'b1, 32'hBFFFFFFF, 1'b0, 1'b0);
      row(1'b0, 32'h0,        32'd0,  1'b0, 1'b1, 1'b1, 1'b0, 32'hBFFFFFFF, 1'b0, 1'b0);
      row(1'b1, 32'h3,        32'd2,  1'b0, 1'b1, 1'b1, 1'b0, 32'hBFFFFFFF, 1'b0, 1'b0);
      row(1'b0, 32'h0,        32'd0,  1'b1, 1'b1, 1'b0, 1'b0, 32'hBFFFFFFF, 1'b0, 1'b0);
      row(1'b0, 32'h0,        32'd0,  1'b0, 1'b1, 1'b0, 1'b1, 32'hC0000000, 1'b0, 1'b0);
      row(1'b0, 32'h0,        32'd0,  1'b0, 1'b1, 1'b0, 1'b0, 32'hC0000000, 1'b1, 1'b0);
      row(1'b0, 32'h0,        32'd0,  1'b0, 1'b1, 1'b1, 1'b0, 32'hC0000000, 1'b0, 1'b0);
      row(1'b1, 32'hFFFF,     32'd40, 1'b0, 1'b1, 1'b1, 1'b0, 32'hC0000000, 1'b0, 1'b1);
      row(1'b1, 32'h1,        32'd1,  1'b0, 1'b1, 1'b1, 1'b0, 32'hC0000000, 1'b0, 1'b1);
      row(1'b0, 32'h0,        32'd0,  1'b1, 1'b1, 1'b0, 1'b0, 32'hC0000000, 1'b0, 1'b1);
      row(1'b0, 32'h0,        32'd0,  1'b0, 1'b1, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1);
      row(1'b0, 32'h0,        32'd0,  1'b0, 1'b1, 1'b0, 1'b0, 32'h80000000, 1'b1, 1'b1);
      row(1'b0, 32'h0,        32'd0,  1'b0, 1'b1, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b1);
      row(1'b1, 32'hFFFFFFFF, 32'd4,  1'b0, 1'b1, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b1);
      row(1'b1, 32'hFFFFFFFF, 32'd0,  1'b0, 1'b1, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b1);
      row(1'b1, 32'hF0000000, 32'd28, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
      row(1'b0, 32'h0,        32'd0,  1'b0, 1'b1, 1'b1, 1'b1, 32'hF0000000, 1'b0, 1'b1);
      row(1'b0, 32'h0,        32'd0,  1'b0, 1'b1, 1'b1, 1'b0, 32'hF0000000, 1'b0, 1'b1);

      tick();
      tick();
      reset = 1'b0;
      chk("rst_ready", {31'd0, input_ready},  32'd1);
      chk("rst_ovld",  {31'd0, output_valid}, 32'd0);
      chk("rst_odata", output_data,           32'd0);
      chk("rst_fdone", {31'd0, flush_done},   32'd0);
      chk("rst_lerr",  {31'd0, len_error},    32'd0);

      for (int i = 0; i < n_rows; i++) begin
         input_valid     = vt[i].v;
         sum_n           = vt[i].sum;
         codeword_length = vt[i].len;
         flush           = vt[i].fl;
         output_ready    = vt[i].ordy;
         tick();
         chk($sformatf("row%0d_ready", i), {31'd0, input_ready},  {31'd0, vt[i].e_ir});
         chk($sformatf("row%0d_ovld", i),  {31'd0, output_valid}, {31'd0, vt[i].e_ov});
         chk($sformatf("row%0d_odata", i), output_data,           vt[i].e_od);
         chk($sformatf("row%0d_fdone", i), {31'd0, flush_done},   {31'd0, vt[i].e_fd});
         chk($sformatf("row%0d_lerr", i),  {31'd0, len_error},    {31'd0, vt[i].e_le});
      end
      input_valid = 1'b0;
      flush       = 1'b0;

      // 64 ones against a stalled sink.
      output_ready = 1'b0;
      input_valid = 1'b1; sum_n = 32'hFFFFFFFF; codeword_length = 32'd32;
      tick();
      chk("stall_ready0", {31'd0, input_ready},  32'd0);
      chk("stall_ovld0",  {31'd0, output_valid}, 32'd0);
      tick();
      chk("stall_ovld1",  {31'd0, output_valid}, 32'd1);
      chk("stall_word1",  output_data,           32'hFFFFFFFF);
      chk("stall_ready1", {31'd0, input_ready},  32'd1);
      tick();
      input_valid = 1'b0;
      chk("stall_ready2", {31'd0, input_ready},  32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("stall_hold%0d_ovld", i),  {31'd0, output_valid}, 32'd1);
         chk($sformatf("stall_hold%0d_data", i),  output_data,           32'hFFFFFFFF);
         chk($sformatf("stall_hold%0d_ready", i), {31'd0, input_ready},  32'd0);
      end
      output_ready = 1'b1;
      tick();
      chk("stall_word2_ovld",  {31'd0, output_valid}, 32'd1);
      chk("stall_word2_data",  output_data,           32'hFFFFFFFF);
      chk("stall_word2_ready", {31'd0, input_ready},  32'd1);
      tick();
      chk("stall_drained", {31'd0, output_valid}, 32'd0);

      // Flush of an empty accumulator.
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("eflush_c1_fd",  {31'd0, flush_done},   32'd0);
      chk("eflush_c1_ov",  {31'd0, output_valid}, 32'd0);
      chk("eflush_c1_ir",  {31'd0, input_ready},  32'd0);
      tick();
      chk("eflush_c2_fd",  {31'd0, flush_done},   32'd1);
      chk("eflush_c2_ov",  {31'd0, output_valid}, 32'd0);
      tick();
      chk("eflush_c3_fd",  {31'd0, flush_done},   32'd0);
      chk("eflush_c3_ir",  {31'd0, input_ready},  32'd1);

      // Reset while flushing behind a stalled output word.
      output_ready = 1'b0;
      input_valid = 1'b1; sum_n = 32'hFFFFFFFF; codeword_length = 32'd32;
      tick();
      input_valid = 1'b0;
      tick();
      input_valid = 1'b1; sum_n = 32'h1F; codeword_length = 32'd5;
      tick();
      input_valid = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      chk("rflush_pre_ov", {31'd0, output_valid}, 32'd1);
      chk("rflush_pre_ir", {31'd0, input_ready},  32'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rflush_ov",    {31'd0, output_valid}, 32'd0);
      chk("rflush_od",    output_data,           32'd0);
      chk("rflush_fd",    {31'd0, flush_done},   32'd0);
      chk("rflush_le",    {31'd0, len_error},    32'd0);
      chk("rflush_ir",    {31'd0, input_ready},  32'd1);
      output_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("rflush_after%0d_fd", i), {31'd0, flush_done},   32'd0);
         chk($sformatf("rflush_after%0d_ov", i), {31'd0, output_valid}, 32'd0);
      end

      // Lengths 7, 32, 0, 13 from a clean reset.
      send(32'h7F, 32'd7);
      send(32'h12345678, 32'd32);
      send(32'hFFFFFFFF, 32'd0);
      send(32'h1FFF, 32'd13);
      tick();
`ifdef VLC_BIT_PACKER_BITCOUNT_EN
      chk("bit_total", bit_total, 32'd52);
`endif
      chk("cnt_lerr", {31'd0, len_error}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/vlc_bit_packer.md
VLC_BIT_PACKER -- requirements
Module: vlc_bit_packer

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high.
REQ-002 Port list SHALL be:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- input_valid  input  1  codeword present.
- sum_n  input  32  codeword value, right-justified.
- codeword_length  input  32  codeword bit count.
- input_ready  output  1  codeword accepted when high with input_valid.
- flush  input  1  pad and drain request, single-cycle pulse.
- output_valid  output  1  output_data holds a word.
- output_data  output  32  packed word, earliest bit at bit 31.
- output_ready  input  1  downstream accepts the word.
- flush_done  output  1  one-cycle pulse when a flush completes.
- len_error  output  1  sticky illegal-length flag.
- bit_total  output  32  total accepted bits, present only with VLC_BIT_PACKER_BITCOUNT_EN.

Function
REQ-003 The block SHALL hold a 64-bit accumulator acc and a 7-bit fill count bit_cnt (0..63), with valid bits MSB-aligned in acc.
REQ-004 input_ready SHALL equal (state==RUN && bit_cnt<32), computed from registered state only.
REQ-005 On accept, the block SHALL append the low L=codeword_length bits of sum_n directly after existing bits, ignore sum_n bits above L-1, and set bit_cnt<=bit_cnt+L.
REQ-006 L=0 SHALL be accepted as a no-op.
REQ-007 For L>32 the codeword SHALL be dropped, len_error SHALL set and stay set until reset, and input_ready SHALL be unaffected.
REQ-008 Word emit SHALL happen when bit_cnt>=32 and (!output_valid || output_ready): output_data<=acc[63:32], acc<<=32, bit_cnt-=32, output_valid<=1.
REQ-009 output_valid SHALL clear when output_ready is high and no new word is loaded that cycle.
REQ-010 output_data SHALL remain stable while output_valid && !output_ready.
REQ-011 Latency: a codeword accepted at edge N that brings bit_cnt to >=32 SHALL give output_valid high after edge N+1, provided the output register is free.
REQ-012 Accept and emit SHALL never occur in the same cycle, because REQ-004 and REQ-008 are mutually exclusive on bit_cnt.
REQ-013 State machine states SHALL be RUN, FLUSH and DONE.
- RUN->FLUSH: flush high in RUN. A codeword accepted on the same edge SHALL be included in the flush.
- FLUSH: input_ready=0. Full words SHALL drain per REQ-008. When 0<bit_cnt<32 and the output register is free, the block SHALL emit acc[63:32] with bits below the valid data zero, then set bit_cnt<=0.
- FLUSH->DONE: bit_cnt==0 and no pending padded word.
- DONE: flush_done=1 for exactly one cycle, then DONE->RUN.
REQ-014 A flush with bit_cnt==0 SHALL emit no word and SHALL assert flush_done two cycles after the flush pulse.
REQ-015 A flush pulse arriving in FLUSH or DONE SHALL be ignored.
REQ-016 Arithmetic on bit_cnt SHALL never wrap, since the maximum reachable value is 31+32=63.

Reset
REQ-017 With reset high at a clk edge, the block SHALL set state=RUN, acc=0, bit_cnt=0, output_valid=0, output_data=0, flush_done=0, len_error=0 and bit_total=0.
REQ-018 Reset mid-flush or mid-stall SHALL discard all pending bits and words without asserting flush_done.

Configuration
REQ-019 With macro VLC_BIT_PACKER_BITCOUNT_EN defined, bit_total SHALL exist and add L on every legal accept, wrapping modulo 2^32.
REQ-020 Without VLC_BIT_PACKER_BITCOUNT_EN, port bit_total and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Codewords (sum_n=0x5,L=3),(0x1FFFFFFF,L=29) with output_ready=1 -> one word 0xBFFFFFFF, bit_cnt=0.
- Codeword (0x3,L=2) then flush -> word 0xC0000000, then flush_done pulse.
- output_ready held 0 for 5 cycles after 64 bits of all-ones -> output_data=0xFFFFFFFF stable, input_ready=0 once bit_cnt>=32, second word follows after ready.
- Codeword with L=40 -> dropped, len_error=1, next (0x1,L=1) packed normally.
- Flush with empty accumulator -> no output_valid, flush_done 2 cycles later; reset asserted during FLUSH -> all outputs zero, no flush_done.
- BITCOUNT_EN build, lengths 7,32,0,13 -> bit_total=52.
